// File: rtl/updown_count_param.sv
// updown_count_param: parametrised up/down modulo counter with enable,
// synchronous load, clock-enable prescaler and a one-cycle terminal-count pulse.
// Build option: define CNT_SATURATE_EN to saturate at 0 / MAX_VAL instead of
// wrapping; tc then pulses on every blocked step. Default build wraps.
module updown_count_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 15,
  parameter int unsigned RST_VAL  = 15,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero
);

  // Prescaler needs at least one bit even when PRESCALE == 1.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W    = WIDTH'(RST_VAL);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             step;

  // Next-state: load beats counting; a step fires when the prescaler completes a phase.
  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    step  = 1'b0;

    if (load) begin
      cnt_d = (load_val > MAX_W) ? MAX_W : load_val;
      pre_d = '0;
    end else if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    if (step) begin
      if (up_dn) begin
        if (cnt_q == MAX_W) begin
          tc_d = 1'b1;
`ifdef CNT_SATURATE_EN
          cnt_d = MAX_W;
`else
          cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d = 1'b1;
`ifdef CNT_SATURATE_EN
          cnt_d = '0;
`else
          cnt_d = MAX_W;
`endif
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_W;
      pre_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
    end
  end

  assign out  = cnt_q;
  assign tc   = tc_q;
  assign zero = (cnt_q == '0);

endmodule
